// File: rtl/oled_frame_streamer_pkg.sv
// Shared definitions for the OLED frame streamer: screen geometry, colours,
// SSD1331 command codes, FSM encoding and the shifter load payload.
package oled_frame_streamer_pkg;

   localparam int unsigned SCREEN_W    = 96;
   localparam int unsigned SCREEN_H    = 64;
   localparam int unsigned X_W         = 7;
   localparam int unsigned Y_W         = 6;
   localparam int unsigned COLOR_W     = 16;
   localparam int unsigned N_CMD_BYTES = 6;

   // RGB565 palette used by the screen renderers
   localparam logic [COLOR_W-1:0] BLACK   = 16'h0000;
   localparam logic [COLOR_W-1:0] WHITE   = 16'hFFFF;
   localparam logic [COLOR_W-1:0] RED     = 16'hF800;
   localparam logic [COLOR_W-1:0] GREEN   = 16'h07E0;
   localparam logic [COLOR_W-1:0] BLUE    = 16'h001F;
   localparam logic [COLOR_W-1:0] YELLOW  = 16'hFFE0;
   localparam logic [COLOR_W-1:0] BROWN   = 16'hA145;
   localparam logic [COLOR_W-1:0] SKYBLUE = 16'h867D;

   localparam logic [7:0] CMD_SET_COLUMN = 8'h15;
   localparam logic [7:0] CMD_SET_ROW    = 8'h75;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_PIX  = 2'd2,
      ST_GAP  = 2'd3
   } state_e;

   typedef struct packed {
      logic               len16;
      logic [COLOR_W-1:0] data;
   } shift_req_t;

   // Address-window preamble: full-screen column range, then row range
   function automatic logic [7:0] cmd_byte(input logic [2:0] idx,
                                           input int unsigned w,
                                           input int unsigned h);
      logic [7:0] b;
      case (idx)
         3'd0:    b = CMD_SET_COLUMN;
         3'd2:    b = 8'(w - 1);
         3'd3:    b = CMD_SET_ROW;
         3'd5:    b = 8'(h - 1);
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/oled_frame_streamer_spi_shifter.sv
// SPI serialiser: CLK_DIV-cycle sclk phases, 8- or 16-bit words MSB-first,
// reloadable on the final bit so consecutive words run back-to-back.
module oled_spi_shifter
   import oled_frame_streamer_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  shift_req_t load_req,
   output logic       sclk,
   output logic       sdin,
   output logic       active,
   output logic       bit_done_c,
   output logic       word_done_c
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic               active_q, active_d;
   logic               sclk_q, sclk_d;
   logic [COLOR_W-1:0] shreg_q, shreg_d;
   logic [3:0]         bit_cnt_q, bit_cnt_d;
   logic [3:0]         last_bit_q, last_bit_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic               phase_end_c;

   always_comb begin
      active_d    = active_q;
      sclk_d      = sclk_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      last_bit_d  = last_bit_q;
      div_cnt_d   = div_cnt_q;
      phase_end_c = (div_cnt_q == DIV_LAST);
      bit_done_c  = active_q && sclk_q && phase_end_c;
      word_done_c = bit_done_c && (bit_cnt_q == last_bit_q);

      if (load) begin
         active_d   = 1'b1;
         sclk_d     = 1'b0;
         shreg_d    = load_req.len16 ? load_req.data : {load_req.data[7:0], 8'h00};
         bit_cnt_d  = '0;
         last_bit_d = load_req.len16 ? 4'd15 : 4'd7;
         div_cnt_d  = '0;
      end else if (active_q) begin
         if (phase_end_c) begin
            div_cnt_d = '0;
            if (!sclk_q) begin
               sclk_d = 1'b1;
            end else if (word_done_c) begin
               // sclk parks high and sdin holds until the next falling edge
               active_d = 1'b0;
            end else begin
               sclk_d    = 1'b0;
               shreg_d   = {shreg_q[COLOR_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active_q   <= 1'b0;
         sclk_q     <= 1'b1;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         last_bit_q <= '0;
         div_cnt_q  <= '0;
      end else begin
         active_q   <= active_d;
         sclk_q     <= sclk_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         last_bit_q <= last_bit_d;
         div_cnt_q  <= div_cnt_d;
      end
   end

   assign sclk   = sclk_q;
   assign sdin   = shreg_q[COLOR_W-1];
   assign active = active_q;

endmodule

// File: rtl/oled_frame_streamer.sv
// Streams full frames to a 96x64 RGB565 OLED: address-window preamble, then
// raster-scanned pixels fetched from a combinational renderer via x/y.
module oled_frame_streamer
   import oled_frame_streamer_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned WIDTH     = SCREEN_W,
   parameter int unsigned HEIGHT    = SCREEN_H,
   parameter int unsigned FRAME_GAP = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [COLOR_W-1:0] oled_data,
   output logic [X_W-1:0]     x,
   output logic [Y_W-1:0]     y,
   output logic               frame_begin,
   output logic               busy,
   output logic               cs_n,
   output logic               sclk,
   output logic               sdin,
   output logic               dc
);

   localparam int unsigned N_PIX = WIDTH * HEIGHT;
   localparam int unsigned PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
   localparam int unsigned GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
   localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(N_PIX - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(FRAME_GAP - 1);
   localparam logic [X_W-1:0]   X_LAST    = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(HEIGHT - 1);
   localparam logic [2:0]       BYTE_LAST = 3'(N_CMD_BYTES - 1);

   state_e           state_q, state_d;
   logic [X_W-1:0]   x_q, x_d;
   logic [Y_W-1:0]   y_q, y_d;
   logic [2:0]       byte_cnt_q, byte_cnt_d;
   logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             frame_begin_q, frame_begin_d;
   logic             busy_q, busy_d;
   logic             cs_n_q, cs_n_d;
   logic             dc_q, dc_d;

   logic             load_c;
   logic             pix_load_c;
   shift_req_t       load_req_c;
   logic             sh_active;
   logic             sh_bit_done_c;
   logic             sh_word_done_c;
   logic             word_end_c;

   oled_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .clk         (clk),
      .reset       (reset),
      .load        (load_c),
      .load_req    (load_req_c),
      .sclk        (sclk),
      .sdin        (sdin),
      .active      (sh_active),
      .bit_done_c  (sh_bit_done_c),
      .word_done_c (sh_word_done_c)
   );

   assign word_end_c = sh_bit_done_c && sh_word_done_c;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (enable) state_d = ST_CMD;
         ST_CMD:  if (word_end_c && byte_cnt_q == BYTE_LAST) state_d = ST_PIX;
         ST_PIX:  if (word_end_c && pix_cnt_q == PIX_LAST) state_d = ST_GAP;
         ST_GAP:  if (gap_cnt_q == GAP_LAST) state_d = enable ? ST_CMD : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      x_d           = x_q;
      y_d           = y_q;
      byte_cnt_d    = byte_cnt_q;
      pix_cnt_d     = pix_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      frame_begin_d = 1'b0;
      busy_d        = busy_q;
      cs_n_d        = cs_n_q;
      dc_d          = dc_q;
      load_c        = 1'b0;
      pix_load_c    = 1'b0;
      load_req_c    = '0;

      case (state_q)
         ST_IDLE: begin
            cs_n_d = 1'b1;
            busy_d = 1'b0;
            if (enable) begin
               frame_begin_d = 1'b1;
               byte_cnt_d    = '0;
            end
         end
         ST_CMD: begin
            if (!sh_active) begin
               // First preamble byte: cs_n drops together with the first sclk fall
               load_c          = 1'b1;
               load_req_c.data = {8'h00, cmd_byte(byte_cnt_q, WIDTH, HEIGHT)};
               cs_n_d          = 1'b0;
               busy_d          = 1'b1;
               dc_d            = 1'b0;
            end else if (word_end_c) begin
               if (byte_cnt_q == BYTE_LAST) begin
                  pix_load_c = 1'b1;
                  pix_cnt_d  = '0;
               end else begin
                  load_c          = 1'b1;
                  load_req_c.data = {8'h00, cmd_byte(byte_cnt_q + 3'd1, WIDTH, HEIGHT)};
                  byte_cnt_d      = byte_cnt_q + 3'd1;
               end
            end
         end
         ST_PIX: begin
            if (word_end_c) begin
               if (pix_cnt_q == PIX_LAST) begin
                  cs_n_d    = 1'b1;
                  busy_d    = 1'b0;
                  gap_cnt_d = '0;
               end else begin
                  pix_load_c = 1'b1;
                  pix_cnt_d  = pix_cnt_q + PIX_W'(1);
               end
            end
         end
         ST_GAP: begin
            cs_n_d     = 1'b1;
            busy_d     = 1'b0;
            byte_cnt_d = '0;
            gap_cnt_d  = gap_cnt_q + GAP_W'(1);
            if (gap_cnt_q == GAP_LAST && enable) frame_begin_d = 1'b1;
         end
         default: ;
      endcase

      // Capture the renderer's colour for the current x,y and step the raster scan
      if (pix_load_c) begin
         load_c           = 1'b1;
         load_req_c.len16 = 1'b1;
         load_req_c.data  = oled_data;
         dc_d             = 1'b1;
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
         end else begin
            x_d = x_q + X_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q           <= '0;
         y_q           <= '0;
         byte_cnt_q    <= '0;
         pix_cnt_q     <= '0;
         gap_cnt_q     <= '0;
         frame_begin_q <= 1'b0;
         busy_q        <= 1'b0;
         cs_n_q        <= 1'b1;
         dc_q          <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         byte_cnt_q    <= byte_cnt_d;
         pix_cnt_q     <= pix_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         frame_begin_q <= frame_begin_d;
         busy_q        <= busy_d;
         cs_n_q        <= cs_n_d;
         dc_q          <= dc_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign frame_begin = frame_begin_q;
   assign busy        = busy_q;
   assign cs_n        = cs_n_q;
   assign dc          = dc_q;

endmodule

// File: doc/oled_frame_streamer.md
Name: oled_frame_streamer

Overview:
- Drives the 96x64 16-bit-colour OLED over a write-only SPI link. It is the initiator side of the screen renderers' pixel interface.
- Scans pixel coordinates in raster order and presents them as x/y to the active combinational screen renderer. It samples the returned oled_data and serialises each pixel MSB-first.
- Each frame is preceded by an address-window command preamble.
- Sits between the screen mux and the OLED pins.

Parameters:
- CLK_DIV, 2: clk cycles per sclk half-period; minimum 1.
- WIDTH, 96: pixel columns.
- HEIGHT, 64: pixel rows.
- FRAME_GAP, 64: clk cycles cs_n is held high between frames.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- enable  in  1  start/continue streaming frames.
- oled_data  in  16  RGB565 colour for current x,y, from the renderer (combinational).
- x  out  7  current pixel column, registered.
- y  out  6  current pixel row, registered.
- frame_begin  out  1  one-clk pulse when a frame preamble starts.
- busy  out  1  high from preamble start to end of last pixel bit.
- cs_n  out  1  SPI chip select, active low.
- sclk  out  1  SPI clock, idle high.
- sdin  out  1  SPI data.
- dc  out  1  0 = command byte, 1 = pixel data.

Behaviour:
- Reset values (the cycle after reset is high):
  - State IDLE.
  - x=0, y=0.
  - frame_begin=0, busy=0.
  - cs_n=1, sclk=1, sdin=0, dc=0.
  - All counters cleared.
- Reset mid-transfer aborts immediately with the same values. No partial byte completes.
- States and transitions:
  - IDLE -> CMD when enable=1. frame_begin pulses on that transition cycle. cs_n goes low and busy goes high on the next cycle.
  - CMD sends 6 bytes with dc=0: 0x15, 0x00, WIDTH-1, 0x75, 0x00, HEIGHT-1. Defaults give 15 00 5F 75 00 3F. CMD -> PIX after the last bit.
  - PIX sends WIDTH*HEIGHT pixels, 16 bits each, with dc=1. PIX -> GAP after the last bit of pixel (WIDTH-1, HEIGHT-1).
  - GAP: cs_n=1, busy=0, sclk=1 for FRAME_GAP cycles. Then -> CMD if enable=1, else -> IDLE.
- Bit timing:
  - Each bit is sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - sdin and dc change only on the cycle sclk falls. The device samples on the rising edge.
  - MSB first. Bits are back-to-back with no idle sclk between bytes or pixels.
  - cs_n stays low continuously from the first command bit to the last pixel bit.
- Pixel fetch:
  - x,y hold a pixel's coordinates for at least 1 cycle before its sample cycle.
  - oled_data is captured into the 16-bit shift register on the cycle that pixel's first bit begins.
  - x,y advance to the next raster position on the cycle after capture.
  - Raster order: x increments; at x=WIDTH-1, x wraps to 0 and y increments; at (WIDTH-1, HEIGHT-1), x and y wrap to (0,0).
  - (0,0) is therefore presented throughout CMD.
- enable deasserted mid-frame: the current frame completes, then GAP -> IDLE. No truncation.
- Timing with defaults: a byte takes 32 clks and a pixel 64 clks. Frame = 192 + 6144*64 = 393,408 clks busy, plus FRAME_GAP.
- Width rules: counters are sized from the parameters. The pixel counter is 13 bits at defaults. Overflow is never reached because WIDTH*HEIGHT is bounded.

Decomposition:
- Shared package holds:
  - Colour localparams: GREEN, RED, BLACK, WHITE, BLUE, BROWN, SKYBLUE, etc.
  - Screen dimensions (96, 64).
  - SSD1331 command codes (SET_COLUMN=0x15, SET_ROW=0x75).
  - State encoding (IDLE, CMD, PIX, GAP).
- One natural sub-module: oled_spi_shifter.
  - Generates sclk from CLK_DIV and serialises 8 or 16 bits.
  - Reports bit_done/word_done. Loads on a load strobe.
  - The top keeps the FSM and the x/y scan.

Test Plan:
- Reset held 3 cycles, then released with enable=0 -> cs_n=1, sclk=1, busy=0, x=0, y=0, no frame_begin for 100 cycles.
- enable=1, CLK_DIV=2 -> one frame_begin pulse, then dc=0 bytes decoded on sclk rising edges = 15 00 5F 75 00 3F. cs_n is low throughout, and each byte spans 32 clks.
- Renderer stub returns 16'hF800 at (0,0) and 16'h07E0 elsewhere -> first pixel bits with dc=1 are 1111100000000000, the second pixel is 0000011111100000, and x=1 after the first capture.
- Monitor x,y at each capture -> the sequence wraps (95,0)->(0,1) and ends at (95,63). Exactly 6144 captures, then cs_n=1 for 64 cycles, then the next frame_begin.
- Assert reset mid-pixel (bit 7 of pixel 200) -> on the next cycle cs_n=1, sclk=1, dc=0, x=0, y=0, busy=0. A clean preamble restarts after release.
- Drop enable at pixel 3000 -> all 6144 pixels are still sent, then GAP, then IDLE with no further frame_begin.
